// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus address map,
// status-word bit positions and serializer state encodings.
package uart_tx_port_pkg;

    localparam logic [31:0] ADDR_UART_DATA = 32'hF000_0030;
    localparam logic [31:0] ADDR_UART_CTRL = 32'hF000_0130;

    localparam int CTRL_NFULL_BIT = 0;
    localparam int CTRL_EMPTY_BIT = 1;
    localparam int CTRL_OVF_BIT   = 2;
    localparam int CTRL_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

endpackage

// File: rtl/uart_tx_port_if.sv
// CPU bus as seen by a memory-mapped device: write/read strobes, address,
// write data, and OR-combined read data.
interface uart_tx_port_if #(
    parameter int BITS = 32
);
    logic            we;
    logic            re;
    logic [BITS-1:0] memAddr;
    logic [BITS-1:0] dataBusIn;
    logic [BITS-1:0] dataBusOut;

    modport master (output we, re, memAddr, dataBusIn, input dataBusOut);
    modport slave  (input we, re, memAddr, dataBusIn, output dataBusOut);
endinterface

// File: rtl/uart_tx_port_sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop frees the slot in the same cycle.
module uart_tx_port_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wrPtr_r;
    logic [PW-1:0]    rdPtr_r;
    logic [CW-1:0]    count_r;
    logic             pushOk_s;
    logic             popOk_s;

    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == '0);
    assign count    = count_r;
    assign dout     = mem_r[rdPtr_r];
    assign pushOk_s = push && (!full || pop);
    assign popOk_s  = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (pushOk_s) begin
            mem_r[wrPtr_r] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (pushOk_s) begin
                wrPtr_r <= wrPtr_r + 1'b1;
            end
            if (popOk_s) begin
                rdPtr_r <= rdPtr_r + 1'b1;
            end
            case ({pushOk_s, popOk_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: DATA writes queue bytes in a FIFO,
// CTRL reports fill level, drain status and a sticky overflow flag.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int              BITS       = 32,
    parameter logic [BITS-1:0] BASE       = ADDR_UART_DATA,
    parameter logic [BITS-1:0] CTRL_BASE  = ADDR_UART_CTRL,
    parameter int              BAUD_DIV   = 565,
    parameter int              FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_port_if.slave  bus,
    output logic           tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BAUD_DIV);

    txState_t        state_r;
    txState_t        nextState_s;
    logic [BW-1:0]   baudCnt_r;
    logic [2:0]      bitCnt_r;
    logic [7:0]      shift_r;
    logic [7:0]      shiftNext_s;
    logic            tx_r;
    logic            txNext_s;
    logic            ovf_r;
    logic            dataHit_s;
    logic            ctrlHit_s;
    logic            bitDone_s;
    logic            statusEmpty_s;
    logic            fifoPush_s;
    logic            fifoPop_s;
    logic            fifoFull_s;
    logic            fifoEmpty_s;
    logic [7:0]      fifoDout_s;
    logic [CW-1:0]   fifoCount_s;
    logic [BITS-1:0] rdData_s;
    logic            unusedBits_s;

    assign dataHit_s     = (bus.memAddr == BASE);
    assign ctrlHit_s     = (bus.memAddr == CTRL_BASE);
    assign fifoPush_s    = bus.we && dataHit_s;
    assign bitDone_s     = (baudCnt_r == BW'(BAUD_DIV - 1));
    assign statusEmpty_s = fifoEmpty_s && (state_r == IDLE);
    assign unusedBits_s  = ^bus.dataBusIn[BITS-1:8];
    assign tx            = tx_r;
    assign bus.dataBusOut = rdData_s;

    uart_tx_port_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifoPush_s),
        .pop   (fifoPop_s),
        .din   (bus.dataBusIn[7:0]),
        .dout  (fifoDout_s),
        .full  (fifoFull_s),
        .empty (fifoEmpty_s),
        .count (fifoCount_s)
    );

    // Serializer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; STOP chains straight into START when more bytes wait.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifoEmpty_s) nextState_s = START;
                else              nextState_s = IDLE;
            end
            START: begin
                if (bitDone_s) nextState_s = DATA;
                else           nextState_s = START;
            end
            DATA: begin
                if (bitDone_s && (bitCnt_r == 3'd7)) nextState_s = STOP;
                else                                  nextState_s = DATA;
            end
            STOP: begin
                if (bitDone_s && !fifoEmpty_s)  nextState_s = START;
                else if (bitDone_s)             nextState_s = IDLE;
                else                            nextState_s = STOP;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Output logic: FIFO pop, next shift contents, and the next line level
    // (tx is registered from these so it changes on the transition edge).
    always_comb begin
        fifoPop_s   = 1'b0;
        shiftNext_s = shift_r;
        txNext_s    = 1'b1;
        case (state_r)
            IDLE: begin
                if (!fifoEmpty_s) begin
                    fifoPop_s   = 1'b1;
                    shiftNext_s = fifoDout_s;
                end else begin
                    fifoPop_s   = 1'b0;
                end
            end
            DATA: begin
                if (bitDone_s && (bitCnt_r != 3'd7)) shiftNext_s = {1'b0, shift_r[7:1]};
                else                                  shiftNext_s = shift_r;
            end
            STOP: begin
                if (bitDone_s && !fifoEmpty_s) begin
                    fifoPop_s   = 1'b1;
                    shiftNext_s = fifoDout_s;
                end else begin
                    fifoPop_s   = 1'b0;
                end
            end
            default: fifoPop_s = 1'b0;
        endcase
        case (nextState_s)
            START:   txNext_s = 1'b0;
            DATA:    txNext_s = shiftNext_s[0];
            default: txNext_s = 1'b1;
        endcase
    end

    // Baud/bit counters, shift register and registered line output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baudCnt_r <= '0;
            bitCnt_r  <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            tx_r    <= txNext_s;
            shift_r <= shiftNext_s;
            if ((state_r == IDLE) || bitDone_s) baudCnt_r <= '0;
            else                                 baudCnt_r <= baudCnt_r + 1'b1;
            if (state_r != DATA)  bitCnt_r <= 3'd0;
            else if (bitDone_s)   bitCnt_r <= bitCnt_r + 3'd1;
            else                  bitCnt_r <= bitCnt_r;
        end
    end

    // Sticky overflow: set when a byte is dropped, cleared by W1C on CTRL bit 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (fifoPush_s && fifoFull_s && !fifoPop_s) begin
            ovf_r <= 1'b1;
        end else if (bus.we && ctrlHit_s && bus.dataBusIn[CTRL_OVF_BIT]) begin
            ovf_r <= 1'b0;
        end
    end

    // Combinational read mux; drives zero when not addressed so it can be ORed.
    always_comb begin
        rdData_s = '0;
        if (bus.re && ctrlHit_s) begin
            rdData_s[CTRL_COUNT_LSB +: CW] = fifoCount_s;
            rdData_s[CTRL_OVF_BIT]         = ovf_r;
            rdData_s[CTRL_EMPTY_BIT]       = statusEmpty_s;
            rdData_s[CTRL_NFULL_BIT]       = ~fifoFull_s;
        end else if (bus.re && dataHit_s) begin
            rdData_s[CW-1:0] = fifoCount_s;
        end else begin
            rdData_s = '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port with BAUD_DIV=4, FIFO_DEPTH=4: register table,
// serial-frame scoreboard, and hand-written overflow/full-pop/reset sequences.
module tb_uart_tx_port;
    import uart_tx_port_pkg::*;

    localparam int BITS  = 32;
    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] DATA_A = ADDR_UART_DATA;
    localparam logic [31:0] CTRL_A = ADDR_UART_CTRL;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;

    uart_tx_port_if #(.BITS(BITS)) bus ();

    uart_tx_port #(
        .BITS       (BITS),
        .BASE       (DATA_A),
        .CTRL_BASE  (CTRL_A),
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];
    int gapQ[$];
    int framesSeen = 0;
    int idleCnt = 0;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expRd;
        string       name;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        bus.we        = 1'b1;
        bus.memAddr   = addr;
        bus.dataBusIn = data;
        @(negedge clk);
        bus.we        = 1'b0;
        bus.memAddr   = 32'd0;
        bus.dataBusIn = 32'd0;
    endtask

    task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus.re      = 1'b1;
        bus.memAddr = addr;
        #1;
        rd          = bus.dataBusOut;
        bus.re      = 1'b0;
        bus.memAddr = 32'd0;
        check(name, rd, exp);
    endtask

    task automatic waitFrames(input int target, input int budget);
        for (int i = 0; i < budget && framesSeen < target; i++) @(negedge clk);
        check("frames_done", 32'(framesSeen), 32'(target));
    endtask

    // Frame monitor: captures 10 bits x BAUD cycles per frame, compares against scoreboard.
    initial begin
        logic [39:0] got;
        logic [39:0] expWave;
        logic [9:0]  fb;
        logic [7:0]  b;
        int          gap;
        bit          abort;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                idleCnt = 0;
            end else if (tx === 1'b1) begin
                idleCnt++;
            end else begin
                gap    = idleCnt;
                abort  = 1'b0;
                got    = 40'd0;
                got[0] = tx;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    got[k] = tx;
                end
                idleCnt = 0;
                if (!abort) begin
                    framesSeen++;
                    gapQ.push_back(gap);
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected got=%h exp=none", got);
                    end else begin
                        b  = expQ.pop_front();
                        fb = {1'b1, b, 1'b0};
                        for (int k = 0; k < 40; k++) expWave[k] = fb[k / BAUD];
                        checks++;
                        if (got !== expWave) begin
                            errors++;
                            $display("FAIL frame_%02h got=%h exp=%h", b, got, expWave);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gapSum;
        logic [7:0] burst[6];

        bus.we = 1'b0; bus.re = 1'b0; bus.memAddr = 32'd0; bus.dataBusIn = 32'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        readCheck("reset_ctrl", CTRL_A, 32'h0000_0003);
        readCheck("reset_data", DATA_A, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Register table: reads compare, writes must leave state untouched.
        vecs[0] = '{1'b0, CTRL_A,        32'd0,          32'h0000_0003, "ctrl_idle"};
        vecs[1] = '{1'b0, DATA_A,        32'd0,          32'h0000_0000, "data_idle"};
        vecs[2] = '{1'b0, 32'hF000_0034, 32'd0,          32'h0000_0000, "unaddr_34"};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'd0,          32'h0000_0000, "unaddr_0"};
        vecs[4] = '{1'b0, 32'hF000_0031, 32'd0,          32'h0000_0000, "unaddr_31"};
        vecs[5] = '{1'b1, CTRL_A,        32'hFFFF_FFFB,  32'd0,         "ctrl_wr_ign"};
        vecs[6] = '{1'b0, CTRL_A,        32'd0,          32'h0000_0003, "ctrl_after_ign"};
        vecs[7] = '{1'b1, 32'hF000_0034, 32'h0000_0055,  32'd0,         "wr_unaddr"};
        vecs[8] = '{1'b0, CTRL_A,        32'd0,          32'h0000_0003, "ctrl_after_unaddr"};
        vecs[9] = '{1'b0, DATA_A,        32'd0,          32'h0000_0000, "data_after_unaddr"};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].isWrite) busWrite(vecs[i].addr, vecs[i].data);
            else                 readCheck(vecs[i].name, vecs[i].addr, vecs[i].expRd);
        end
        repeat (50) @(negedge clk);
        check("no_frame_idle", 32'(framesSeen), 32'd0);

        // Single frame and start latency.
        expQ.push_back(8'hA5);
        busWrite(DATA_A, 32'h0000_01A5);
        check("lat_tx_hi", 32'(tx), 32'd1);
        readCheck("ctrl_queued", CTRL_A, 32'h0000_0101);
        readCheck("data_count1", DATA_A, 32'h0000_0001);
        @(negedge clk);
        check("lat_tx_lo", 32'(tx), 32'd0);
        readCheck("ctrl_busy", CTRL_A, 32'h0000_0001);
        waitFrames(1, 80);
        repeat (2) @(negedge clk);
        readCheck("ctrl_drained", CTRL_A, 32'h0000_0003);

        // Six back-to-back writes: one pops, four queue, sixth overflows.
        base = framesSeen;
        gapQ.delete();
        burst = '{8'h3C, 8'h81, 8'h00, 8'hFF, 8'h5A, 8'hE7};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expQ.push_back(burst[i]);
            busWrite(DATA_A, {24'hABCD00, burst[i]});
        end
        readCheck("ctrl_ovf", CTRL_A, 32'h0000_0404);
        readCheck("data_count4", DATA_A, 32'h0000_0004);
        busWrite(CTRL_A, 32'h0000_0004);
        readCheck("ctrl_w1c", CTRL_A, 32'h0000_0400);
        waitFrames(base + 5, 5 * 40 + 50);
        gapSum = 0;
        for (int i = 1; i < gapQ.size(); i++) gapSum += gapQ[i];
        check("burst_no_gap", 32'(gapSum), 32'd0);
        repeat (60) @(negedge clk);
        check("burst_frames", 32'(framesSeen - base), 32'd5);
        check("burst_sb_empty", 32'(expQ.size()), 32'd0);
        readCheck("ctrl_idle2", CTRL_A, 32'h0000_0003);

        // Push into a full FIFO on the exact cycle STOP pops.
        base = framesSeen;
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(burst[i]);
            busWrite(DATA_A, {24'd0, burst[i]});
        end
        repeat (36) @(negedge clk);
        readCheck("ctrl_full", CTRL_A, 32'h0000_0400);
        expQ.push_back(burst[5]);
        busWrite(DATA_A, {24'd0, burst[5]});
        readCheck("ctrl_full_pop_push", CTRL_A, 32'h0000_0400);
        waitFrames(base + 6, 6 * 40 + 50);
        repeat (4) @(negedge clk);
        readCheck("ctrl_idle3", CTRL_A, 32'h0000_0003);
        check("full_sb_empty", 32'(expQ.size()), 32'd0);

        // Reset in the middle of a frame's data bits.
        base = framesSeen;
        busWrite(DATA_A, 32'h0000_0000);
        busWrite(DATA_A, 32'h0000_0012);
        busWrite(DATA_A, 32'h0000_0034);
        repeat (10) @(negedge clk);
        check("pre_reset_tx", 32'(tx), 32'd0);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        readCheck("ctrl_after_reset", CTRL_A, 32'h0000_0003);
        repeat (100) @(negedge clk);
        check("no_frame_after_reset", 32'(framesSeen), 32'(base));
        check("tx_idle_after_reset", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
